instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of the IF/ID pipeline register and drives its PC-address and instruction inputs.
- Holds the program counter and issues one instruction-memory request at a time over a variable-latency req/ready interface.
- Presents each fetched instruction with its PC and a valid flag.
- Handles downstream stall with a one-entry skid buffer and handles branch redirects, including discarding an in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential instructions

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
stall  input  1  IF/ID cannot accept; output registers must hold
branch_taken  input  1  redirect request from execute, single-cycle pulse
branch_target  input  32  redirect PC, sampled when branch_taken=1
imem_req  output  1  instruction memory request
imem_addr  output  32  request address; stable while imem_req=1 until imem_ready
imem_ready  input  1  response valid this cycle, qualifies imem_rdata
imem_rdata  input  32  instruction word
output_pc_address  output  32  PC of presented instruction, feeds IF/ID input_pc_address
output_instruc  output  32  instruction word, feeds IF/ID input_instruc
output_valid  output  1  output pair is a real instruction (0 = bubble)

Behaviour:
- One clock. Reset is asynchronous and active-high; the reset port is named reset and the clock port is named clock.
- Reset values:
  - pc = RESET_PC; state = FETCH.
  - output_valid = 0; output_pc_address = 0; output_instruc = 0.
  - skid buffer empty; saved_target = 0.
- Combinational outputs: imem_req = 1 in FETCH and DISCARD, else 0. imem_addr = pc in all states.
- At most one outstanding request. Address and imem_req are held until imem_ready.
- Output register "can accept" = !stall || !output_valid.
- FETCH:
  - imem_ready and can accept: output <= {pc, imem_rdata}, output_valid <= 1, pc <= pc+PC_STEP; stay FETCH. Back-to-back fetch is possible with 0-wait memory, 1 instruction per cycle.
  - imem_ready and cannot accept: skid <= {pc, imem_rdata}, pc <= pc+PC_STEP; go HOLD.
  - no imem_ready and !stall: output_valid <= 0 (bubble).
- HOLD:
  - imem_req = 0.
  - When stall=0: output <= skid, output_valid <= 1; go FETCH.
  - While stall=1: everything holds.
- DISCARD:
  - A redirect arrived while the request was outstanding.
  - Keep imem_req=1 at the old pc until imem_ready; drop the response.
  - On ready: pc <= saved_target; go FETCH.
  - While waiting, output_valid <= 0.
- Redirect: branch_taken has top priority over stall and imem_ready.
  - output_valid <= 0 next cycle, even if stall=1. This is the flush.
  - Skid buffer is cleared.
  - FETCH with imem_ready same cycle: response dropped, pc <= branch_target, stay FETCH.
  - FETCH without imem_ready: saved_target <= branch_target; go DISCARD.
  - HOLD: pc <= branch_target; go FETCH.
  - DISCARD: saved_target overwritten by the newest target.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- No misalignment check; the target is used as given.
- Reset mid-request: state returns to FETCH and imem_req reasserts at RESET_PC after release. The memory model must abandon the old request on reset.

Test Plan:
- Reset, RESET_PC=0, memory ready every cycle returning addr+32'h100 -> outputs (0,0x100), (4,0x104), (8,0x108) on 3 consecutive cycles, output_valid=1 throughout.
- Memory latency 2 (ready every 3rd cycle) -> output_valid pattern 0,0,1 repeating. imem_addr is stable for 3 cycles per request. PCs go 0,4,8.
- Stall for 3 cycles while a response arrives -> output holds (4,0x104), state HOLD, imem_req=0. After release, (8,0x108) is presented, then fetching resumes at 12.
- branch_taken with target 0x40 while a request at pc=8 is pending (latency 2) -> output_valid=0 next cycle, the pc=8 response is dropped, next request addr=0x40, next valid output is (0x40,0x140).
- branch_taken with target 0x80 while stall=1 and output valid -> output_valid=0 next cycle despite the stall, skid discarded, first valid output is (0x80,0x180).
- Start PC 32'hFFFF_FFF8, 0-wait memory -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert reset mid-latency -> all outputs 0 immediately (async), fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// Fetch stage feeding the IF/ID register: one outstanding imem request, one-entry
// skid buffer for downstream stall, and branch redirect with in-flight discard.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] output_pc_address,
  output logic [31:0] output_instruc,
  output logic        output_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_valid_q, out_valid_d;
  logic        can_accept;

  assign can_accept        = !stall || !out_valid_q;
  assign imem_req          = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr         = pc_q;
  assign output_pc_address = out_pc_q;
  assign output_instruc    = out_instr_q;
  assign output_valid      = out_valid_q;

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no branch
    // of the decode below can leave a signal unassigned and infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    skid_pc_d      = skid_pc_q;
    skid_instr_d   = skid_instr_q;
    out_pc_d       = out_pc_q;
    out_instr_d    = out_instr_q;
    out_valid_d    = out_valid_q;

    if (branch_taken) begin
      // Redirect flushes the output even under stall and empties the skid.
      out_valid_d  = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = branch_target;
          end else begin
            saved_target_d = branch_target;
            state_d        = DISCARD;
          end
        end
        HOLD: begin
          pc_d    = branch_target;
          state_d = FETCH;
        end
        DISCARD: begin
          saved_target_d = branch_target;
          if (imem_ready) begin
            pc_d    = branch_target;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + PC_STEP;
            if (can_accept) begin
              out_pc_d    = pc_q;
              out_instr_d = imem_rdata;
              out_valid_d = 1'b1;
            end else begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata;
              state_d      = HOLD;
            end
          end else if (!stall) begin
            out_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_pc_d    = skid_pc_q;
            out_instr_d = skid_instr_q;
            out_valid_d = 1'b1;
            state_d     = FETCH;
          end
        end
        DISCARD: begin
          // The stale response is consumed here and never reaches the output.
          out_valid_d = 1'b0;
          if (imem_ready) begin
            pc_d    = saved_target_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      saved_target_q <= '0;
      skid_pc_q      <= '0;
      skid_instr_q   <= '0;
      out_pc_q       <= '0;
      out_instr_q    <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
      skid_pc_q      <= skid_pc_d;
      skid_instr_q   <= skid_instr_d;
      out_pc_q       <= out_pc_d;
      out_instr_q    <= out_instr_d;
      out_valid_q    <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// Bench for instruction_fetch: directed scenarios plus random stall/branch/latency
// traffic, compared against a queue-based behavioural model of the fetch stream.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] output_pc_address;
  logic [31:0] output_instruc;
  logic        output_valid;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .output_pc_address(output_pc_address),
    .output_instruc   (output_instruc),
    .output_valid     (output_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the fetch stream as a next PC, a parked entry (queue of at
  // most one), an optional pending-discard target and the presented output.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  logic [31:0] m_pc, m_tgt, m_out_pc, m_out_ins;
  bit          m_drop, m_out_v;
  entry_t      m_skid[$];

  // Memory model: one request at a time, latency fixed or random per request.
  bit          mem_busy;
  int          mem_cnt;
  int          lat_mode;
  logic [31:0] mem_addr;

  task automatic model_reset();
    m_pc      = 32'h0;
    m_tgt     = 32'h0;
    m_drop    = 1'b0;
    m_out_v   = 1'b0;
    m_out_pc  = 32'h0;
    m_out_ins = 32'h0;
    m_skid.delete();
    mem_busy  = 1'b0;
  endtask

  function automatic void model_step(bit st, bit br, logic [31:0] tg, bit rdy, logic [31:0] rd);
    bit     take;
    entry_t e;
    take = !st || !m_out_v;
    if (br) begin
      m_out_v = 1'b0;
      if (m_skid.size() != 0) begin
        m_skid.delete();
        m_pc = tg;
      end else if (m_drop) begin
        if (rdy) begin
          m_drop = 1'b0;
          m_pc   = tg;
        end else begin
          m_tgt = tg;
        end
      end else if (rdy) begin
        m_pc = tg;
      end else begin
        m_drop = 1'b1;
        m_tgt  = tg;
      end
    end else if (m_skid.size() != 0) begin
      if (!st) begin
        e         = m_skid.pop_front();
        m_out_pc  = e.pc;
        m_out_ins = e.ins;
        m_out_v   = 1'b1;
      end
    end else if (m_drop) begin
      m_out_v = 1'b0;
      if (rdy) begin
        m_drop = 1'b0;
        m_pc   = m_tgt;
      end
    end else if (rdy) begin
      if (take) begin
        m_out_pc  = m_pc;
        m_out_ins = rd;
        m_out_v   = 1'b1;
      end else begin
        m_skid.push_back('{pc: m_pc, ins: rd});
      end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_out_v = 1'b0;
    end
  endfunction

  // One clock: drive inputs and memory response, check request side, clock,
  // advance the model, then check the registered outputs.
  task automatic cycle(input bit st, input bit br, input logic [31:0] tg);
    stall         = st;
    branch_taken  = br;
    branch_target = tg;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
      end else begin
        check("addr_stable", imem_addr, mem_addr);
      end
    end
    imem_ready = imem_req && mem_busy && (mem_cnt == 0);
    imem_rdata = imem_ready ? imem_addr + 32'h100 : $urandom;
    check("imem_req", 32'(imem_req), 32'(m_skid.size() == 0));
    check("imem_addr", imem_addr, m_pc);
    @(posedge clock);
    model_step(st, br, tg, imem_ready, imem_rdata);
    if (imem_ready) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    #1;
    check("out_valid", 32'(output_valid), 32'(m_out_v));
    check("out_pc", output_pc_address, m_out_pc);
    check("out_ins", output_instruc, m_out_ins);
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b0;
    imem_rdata    = 32'h0;
    lat_mode      = 0;
    model_reset();
    #12;
    check("rst_valid", 32'(output_valid), 32'h0);
    check("rst_pc", output_pc_address, 32'h0);
    check("rst_ins", output_instruc, 32'h0);
    check("rst_req", 32'(imem_req), 32'h1);
    check("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;

    // Zero-wait memory: one instruction per cycle.
    lat_mode = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      check("tp1_pc", output_pc_address, 32'(4 * i));
      check("tp1_ins", output_instruc, 32'(4 * i) + 32'h100);
      check("tp1_valid", 32'(output_valid), 32'h1);
    end

    // Two-cycle latency: bubble, bubble, valid.
    lat_mode = 2;
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      check("tp2_valid", 32'(output_valid), 32'(k % 3 == 2));
    end

    // Stall while a response lands: parked in the skid, then drained.
    lat_mode = 0;
    cycle(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect while a latency-2 request is outstanding.
    lat_mode = 2;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h40);
    check("tp4_flush", 32'(output_valid), 32'h0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect under stall with a valid output and a full skid.
    lat_mode = 0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h80);
    check("tp5_flush", 32'(output_valid), 32'h0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_pc0", output_pc_address, 32'hFFFF_FFF8);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_pc1", output_pc_address, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_pc2", output_pc_address, 32'h0000_0000);

    // Asynchronous reset in the middle of a latency-3 request.
    lat_mode = 3;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    #3;
    reset = 1'b1;
    #1;
    check("arst_pc", output_pc_address, 32'h0);
    check("arst_ins", output_instruc, 32'h0);
    check("arst_valid", 32'(output_valid), 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_req", 32'(imem_req), 32'h1);
    model_reset();
    #2;
    reset = 1'b0;
    lat_mode = 1;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 32'h0);

    // Random traffic.
    lat_mode = -1;
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(9) < 3, $urandom_range(99) < 8, $urandom & 32'hFFFF_FFFC);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
